fpu_mul_arbiter: RTL and testbench
==================================

// Module: fpu_mul_arbiter
// PURPOSE
//  Shares one single-precision FP multiplier among NUM_REQ requesters.
//  - Round-robin grant; one operation in flight at a time.
//  - Drives the multiplier's strobe/ack handshake: operand A, then B, then result Z.
//  - Returns the product to the granted requester only.
//  - Sits between the co-processor issue logic and the multiplier datapath.
// PARAMETERS
//  NUM_REQ  4            number of requesters (2..8)
//  IDX_W    $clog2(NUM_REQ)  width of owner index
//  CNT_W    16           width of completed-operation counter
// PORTS
//  clk         in   1           clock
//  rst         in   1           reset, synchronous, active-high
//  req_valid   in   NUM_REQ     per-requester operation request
//  req_a       in   32*NUM_REQ  operand A, requester i at [32*i+:32]
//  req_b       in   32*NUM_REQ  operand B, same packing
//  req_ready   out  NUM_REQ     one-hot accept; transfer when valid&ready
//  rsp_valid   out  NUM_REQ     one-hot result valid, to owner only
//  rsp_data    out  32          product (IEEE-754 single)
//  rsp_ready   in   NUM_REQ     requester accepts result
//  mul_a       out  32          operand A to multiplier
//  mul_a_stb   out  1           operand A strobe
//  mul_a_ack   in   1           multiplier accepts A when stb&ack
//  mul_b       out  32          operand B to multiplier
//  mul_b_stb   out  1           operand B strobe
//  mul_b_ack   in   1           multiplier accepts B when stb&ack
//  mul_z       in   32          result from multiplier
//  mul_z_stb   in   1           result strobe
//  mul_z_ack   out  1           result accept; transfer when stb&ack
//  busy        out  1           high in any state but IDLE
//  owner       out  IDX_W       index of current/last grant
//  op_count    out  CNT_W       completed operations; wraps at 2^CNT_W
// BEHAVIOUR
//  Reset:
//  - state=IDLE; all strobes, acks, ready and valid outputs 0.
//  - rsp_data, mul_a, mul_b = 0; op_count = 0.
//  - last-grant pointer = NUM_REQ-1, so requester 0 wins first.
//  Outputs: all Moore decodes of registered state.
//  - req_ready is combinational from state, req_valid and the pointer.
//  FSM: IDLE -> SEND_A -> SEND_B -> WAIT_Z -> RESP -> IDLE.
//  - IDLE: grant = first req_valid[i] searching from pointer+1 with wrap.
//    - req_ready[grant]=1.
//    - On transfer: latch a, b and owner=grant; go SEND_A.
//    - No valid requests: stay in IDLE, nothing asserted.
//  - SEND_A: mul_a_stb=1, mul_a=a_reg. On mul_a_stb&mul_a_ack, go SEND_B.
//  - SEND_B: mul_b_stb=1, mul_b=b_reg. On mul_b_stb&mul_b_ack, go WAIT_Z.
//  - WAIT_Z: mul_z_ack=1. On mul_z_stb, latch rsp_data=mul_z; go RESP.
//  - RESP: rsp_valid[owner]=1.
//    - On rsp_ready[owner], pointer=owner and op_count++; go IDLE.
//    - rsp_ready of non-owners is ignored.
//  - Stall: any handshake may stall indefinitely; no timeout; held values stay stable.
//  Latency: accept at cycle 0; SEND_A entered at cycle 1.
//  - Minimum overhead is 4 cycles plus multiplier compute plus requester response.
//  - No new request accepted until RESP completes. A request deasserted before acceptance is dropped.
//  Fairness: a requester just served has lowest priority next round.
//  - Simultaneous requests: the one nearest above the pointer wins.
//  Reset mid-operation: return to IDLE and drop the operation, no response.
//  - The multiplier shares rst, so both restart aligned.
// STRUCTURE
//  - Shared package fpu_pkg: FP_W=32, arbiter state encoding (3-bit localparams).
//  - Sub-module rr_arbiter(NUM_REQ): combinational round-robin grant from req and pointer.
//    - Outputs a one-hot grant and its index.
//  - Top holds the FSM, operand/result registers, pointer and counter.
// TESTING
//  - Single op: req0 a=0x40400000, b=0x40000000 -> rsp_valid[0], rsp_data=0x40C00000, op_count=1.
//  - Contention: req0..3 all valid from reset -> served in order 0,1,2,3.
//    Keep req0 valid after its service -> it is served after 3, not before.
//  - Back-pressure: hold rsp_ready[2]=0 for 10 cycles.
//    -> rsp_valid[2] and rsp_data stable; no req_ready asserted meanwhile.
//  - Slow multiplier: delay mul_a_ack 5 cycles -> mul_a_stb and mul_a held; result still correct.
//  - Reset in WAIT_Z -> next cycle IDLE, busy=0, no rsp_valid; next request served normally.
//  - Counter wrap (CNT_W=2): 5 ops -> op_count=1.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP multiplier arbiter: datapath width and
// arbiter state encoding.
package fpu_pkg;

  localparam int FP_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT_Z = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/fpu_mul_arbiter_rr_arbiter.sv
// Combinational round-robin grant: the first active request strictly after
// the last-grant pointer wins, searching upward with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    // NOTE: every output gets a default before the search loop, otherwise
    // the conditional assignments below would infer latches.
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_j         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_j = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any          = 1'b1;
        o_grant[w_j]   = 1'b1;
        o_grant_idx    = w_j;
      end
    end
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one single-precision multiplier among NUM_REQ requesters: round-robin
// grant, one operation in flight, strobe/ack sequencing of A, B and Z.
module fpu_mul_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [FP_W-1:0]         mul_a,
  output logic                    mul_a_stb,
  input  logic                    mul_a_ack,
  output logic [FP_W-1:0]         mul_b,
  output logic                    mul_b_stb,
  input  logic                    mul_b_ack,
  input  logic [FP_W-1:0]         mul_z,
  input  logic                    mul_z_stb,
  output logic                    mul_z_ack,
  output logic                    busy,
  output logic [IDX_W-1:0]        owner,
  output logic [CNT_W-1:0]        op_count
);

  arb_state_e         r_state;
  arb_state_e         w_next;
  logic [FP_W-1:0]    r_a;
  logic [FP_W-1:0]    r_b;
  logic [FP_W-1:0]    r_z;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_rsp_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // The grant is a subset of req_valid, so any grant in IDLE is a transfer.
  assign w_accept   = (r_state == ST_IDLE) && w_any;
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_owner];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values, independent of statement order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    mul_a_stb = 1'b0;
    mul_b_stb = 1'b0;
    mul_z_ack = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_grant;
        if (w_any) w_next = ST_SEND_A;
      end
      ST_SEND_A: begin
        mul_a_stb = 1'b1;
        if (mul_a_ack) w_next = ST_SEND_B;
      end
      ST_SEND_B: begin
        mul_b_stb = 1'b1;
        if (mul_b_ack) w_next = ST_WAIT_Z;
      end
      ST_WAIT_Z: begin
        mul_z_ack = 1'b1;
        if (mul_z_stb) w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[r_owner] = 1'b1;
        if (rsp_ready[r_owner]) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand/result registers hold their values through any stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_z     <= '0;
      r_owner <= '0;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= req_a[w_grant_idx*FP_W +: FP_W];
        r_b     <= req_b[w_grant_idx*FP_W +: FP_W];
        r_owner <= w_grant_idx;
      end
      if ((r_state == ST_WAIT_Z) && mul_z_stb) r_z <= mul_z;
      if (w_rsp_done) begin
        r_ptr   <= r_owner;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign mul_a    = r_a;
  assign mul_b    = r_b;
  assign rsp_data = r_z;
  assign owner    = r_owner;
  assign op_count = r_count;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Scoreboard bench for fpu_mul_arbiter: directed products with hand-computed
// IEEE-754 results, a strobe/ack multiplier model and a response monitor.
module tb_fpu_mul_arbiter;

  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [32*N-1:0]  req_a;
  logic [32*N-1:0]  req_b;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_data;
  logic [N-1:0]     rsp_ready;
  logic [31:0]      mul_a;
  logic             mul_a_stb;
  logic             mul_a_ack;
  logic [31:0]      mul_b;
  logic             mul_b_stb;
  logic             mul_b_ack;
  logic [31:0]      mul_z;
  logic             mul_z_stb;
  logic             mul_z_ack;
  logic             busy;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] op_count;

  fpu_mul_arbiter #(.NUM_REQ(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .busy(busy), .owner(owner), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed products: 3*2, 1.5*1.5, 2*4, -1*5, 0.5*10, 1*1.
  logic [31:0] va [6] = '{32'h40400000, 32'h3FC00000, 32'h40000000,
                          32'hBF800000, 32'h3F000000, 32'h3F800000};
  logic [31:0] vb [6] = '{32'h40000000, 32'h3FC00000, 32'h40800000,
                          32'h40A00000, 32'h41200000, 32'h3F800000};
  logic [31:0] vz [6] = '{32'h40C00000, 32'h40100000, 32'h41000000,
                          32'hC0A00000, 32'h40A00000, 32'h3F800000};

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   pq [N][4];
  int   pq_n [N] = '{0, 0, 0, 0};
  int   n_vec = 0;
  int   n_mis = 0;
  int   a_delay = 0;
  int   z_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  task automatic expect_rsp(input int idx, input int v);
    sb.push_back('{idx, vz[v]});
  endtask

  task automatic enqueue(input int idx, input int v);
    pq[idx][pq_n[idx]] = v;
    pq_n[idx]++;
  endtask

  function automatic int pend_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += pq_n[i];
    return t;
  endfunction

  // Multiplier answers only known ordered operand pairs.
  function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 6; i++)
      if (va[i] == a && vb[i] == b) return vz[i];
    return 32'hDEADBEEF;
  endfunction

  task automatic wait_done(input int budget, input string name);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && pend_total() == 0 && !busy) done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  // Requesters: hold valid until accepted, then present the next queued op.
  initial begin
    logic [N-1:0] hs;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && pq_n[i] > 0) begin
          for (int k = 0; k < 3; k++) pq[i][k] = pq[i][k+1];
          pq_n[i]--;
        end
        req_valid[i] = (pq_n[i] > 0);
        if (pq_n[i] > 0) begin
          req_a[32*i +: 32] = va[pq[i][0]];
          req_b[32*i +: 32] = vb[pq[i][0]];
        end
      end
    end
  end

  // Multiplier model with programmable A-ack and Z delays.
  initial begin
    int          m_st, wcnt, zcnt;
    bit          a_seen;
    logic [31:0] hold_a, m_a, m_b;
    mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0; mul_z = '0;
    m_st = 0; wcnt = 0; zcnt = 0; a_seen = 1'b0; hold_a = '0; m_a = '0; m_b = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0;
        m_st = 0; wcnt = 0; zcnt = 0; a_seen = 1'b0;
      end else begin
        case (m_st)
          0: if (mul_a_stb || a_seen) begin
               if (a_seen) begin
                 check("mul_a_stb_held", mul_a_stb, 1);
                 check("mul_a_held", mul_a, hold_a);
               end else begin
                 a_seen = 1'b1;
                 hold_a = mul_a;
               end
               if (wcnt >= a_delay) begin
                 mul_a_ack = 1'b1; m_a = mul_a; m_st = 1;
               end else wcnt++;
             end
          1: begin
               mul_a_ack = 1'b0;
               if (mul_b_stb) begin mul_b_ack = 1'b1; m_b = mul_b; m_st = 2; end
             end
          2: begin
               mul_b_ack = 1'b0;
               if (zcnt >= z_delay) begin
                 mul_z = lookup(m_a, m_b); mul_z_stb = 1'b1; m_st = 3;
               end else zcnt++;
             end
          default: begin
               mul_z_stb = 1'b0; m_st = 0; wcnt = 0; zcnt = 0; a_seen = 1'b0;
             end
        endcase
      end
    end
  end

  // Monitor: every response handshake is compared with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (rsp_valid & rsp_ready) != '0) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_rsp: rsp_valid=%b data=%08h, none expected", rsp_valid, rsp_data);
        end else begin
          e = sb.pop_front();
          check("rsp_owner", rsp_valid, 32'(1) << e.idx);
          check("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    bit          seen;
    rst       = 1'b1;
    rsp_ready = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mul_a_stb", mul_a_stb, 0);
    check("rst_mul_b_stb", mul_b_stb, 0);
    check("rst_mul_z_ack", mul_z_ack, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_op_count", op_count, 0);

    // Single operation: 3.0 * 2.0 from requester 0.
    expect_rsp(0, 0);
    enqueue(0, 0);
    wait_done(60, "single_op");
    check("single_op_count", op_count, 1);
    check("single_owner", owner, 0);

    // Contention from reset: order 0,1,2,3 then requester 0 again; 5 ops wrap to 1.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("cont_count_clr", op_count, 0);
    expect_rsp(0, 0); expect_rsp(1, 1); expect_rsp(2, 2); expect_rsp(3, 3); expect_rsp(0, 4);
    enqueue(0, 0); enqueue(0, 4); enqueue(1, 1); enqueue(2, 2); enqueue(3, 3);
    wait_done(300, "contention");
    check("wrap_op_count", op_count, 1);
    check("cont_owner", owner, 0);

    // Back-pressure on requester 2 with requester 0 waiting.
    rsp_ready[2] = 1'b0;
    expect_rsp(2, 3);
    enqueue(2, 3);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid[2]) seen = 1'b1;
    end
    if (!seen) fail_now("bp_rsp_valid");
    expect_rsp(0, 5);
    enqueue(0, 5);
    held = rsp_data;
    check("bp_data", held, vz[3]);
    repeat (10) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 4'b0100);
      check("bp_rsp_data", rsp_data, held);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready[2] = 1'b1;
    wait_done(100, "backpressure");
    check("bp_op_count", op_count, 3);

    // Slow multiplier: A ack delayed 5 cycles.
    a_delay = 5;
    expect_rsp(3, 1);
    enqueue(3, 1);
    wait_done(100, "slow_mul");
    a_delay = 0;
    check("slow_op_count", op_count, 0);

    // Reset while waiting on Z: operation dropped silently.
    z_delay = 5;
    enqueue(1, 5);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (mul_z_ack) seen = 1'b1;
    end
    if (!seen) fail_now("wait_z_entry");
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    z_delay = 0;
    check("rstz_busy", busy, 0);
    check("rstz_rsp_valid", rsp_valid, 0);
    check("rstz_mul_z_ack", mul_z_ack, 0);
    check("rstz_op_count", op_count, 0);
    repeat (5) @(negedge clk);
    check("rstz_idle", busy, 0);

    expect_rsp(1, 2);
    enqueue(1, 2);
    wait_done(60, "post_reset_op");
    check("post_rst_count", op_count, 1);
    check("post_rst_owner", owner, 1);

    // Pointer at 1: simultaneous 0,2,3 are served 2,3,0.
    expect_rsp(2, 0); expect_rsp(3, 4); expect_rsp(0, 5);
    enqueue(3, 4); enqueue(0, 5); enqueue(2, 0);
    wait_done(200, "rr_from_ptr1");
    check("final_op_count", op_count, 0);
    check("final_owner", owner, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
